// File: rtl/iob_axi_burst_split_pkg.sv
// iob_axi_burst_split_pkg
// Shared types and constants for the AXI read burst splitter.
// Optional feature macro used by this slice: IOB_AXI_BURST_SPLIT_4K_EN.
package iob_axi_burst_split_pkg;

    // Splitter control states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CALC      = 2'd1,
        ISSUE     = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    // AXI bursts must not cross this many bytes.
    localparam int AXI_BOUNDARY_BYTES = 4096;

    // Number of low address bits that give the offset inside a boundary page.
    localparam int BOUNDARY_OFFSET_W = 12;

    // Beat counts carry one extra bit so that 2^AXI_LEN_W and the full
    // remaining count can be represented together.
    localparam int BEATS_EXTRA_W = 1;

    function automatic int beats_width(input int len_w);
        return len_w + BEATS_EXTRA_W;
    endfunction

endpackage

// File: rtl/iob_axi_burst_split_if.sv
// iob_axi_burst_split_if
// Burst command port between the splitter and the read engine.
// The master side issues run/addr/length; the slave side returns ready/error.
interface iob_axi_burst_split_if #(
    parameter int ADDR_W    = 32,
    parameter int AXI_LEN_W = 8
);
    logic                 run;
    logic [ADDR_W-1:0]    addr;
    logic [AXI_LEN_W-1:0] length;
    logic                 ready;
    logic                 error;

    modport master (
        output run,
        output addr,
        output length,
        input  ready,
        input  error
    );

    modport slave (
        input  run,
        input  addr,
        input  length,
        output ready,
        output error
    );
endinterface

// File: rtl/iob_axi_burst_len_calc.sv
// iob_axi_burst_len_calc
// Combinational beat count for the next burst:
//   beats = min(remaining, 2^AXI_LEN_W [, words left in the current 4 KB page])
// The 4 KB page clamp is present only when IOB_AXI_BURST_SPLIT_4K_EN is defined.
module iob_axi_burst_len_calc
    import iob_axi_burst_split_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int AXI_LEN_W = 8,
    parameter int LEN_W     = 16
) (
    input  logic [ADDR_W-1:0]               addr_i,
    input  logic [beats_width(LEN_W)-1:0]   remaining_i,
    output logic [beats_width(LEN_W)-1:0]   beats_o
);
    localparam int BW    = beats_width(LEN_W);
    localparam int CW_A  = ((LEN_W > AXI_LEN_W) ? LEN_W : AXI_LEN_W) + 2;
    localparam int CW    = (CW_A > BOUNDARY_OFFSET_W + 2) ? CW_A : BOUNDARY_OFFSET_W + 2;

    logic [CW-1:0] rem_w;
    logic [CW-1:0] max_w;
    logic [CW-1:0] min_len_w;
    logic [CW-1:0] min_w;
    logic          unused_addr_bits;

    // Only the in-page offset matters; the upper address bits are folded away.
    assign unused_addr_bits = ^addr_i;

`ifdef IOB_AXI_BURST_SPLIT_4K_EN
    localparam int BYTE_SHIFT = $clog2(DATA_W / 8);

    logic [BOUNDARY_OFFSET_W:0] bytes_to_page;
    logic [CW-1:0]              words_to_page;

    // Words left before the next 4 KB page, then clamp the burst to it.
    always_comb begin
        rem_w         = CW'(remaining_i);
        max_w         = CW'(1) << AXI_LEN_W;
        min_len_w     = (rem_w < max_w) ? rem_w : max_w;
        bytes_to_page = (BOUNDARY_OFFSET_W + 1)'(AXI_BOUNDARY_BYTES)
                      - {1'b0, addr_i[BOUNDARY_OFFSET_W-1:0]};
        words_to_page = CW'(bytes_to_page >> BYTE_SHIFT);
        min_w         = (words_to_page < min_len_w) ? words_to_page : min_len_w;
        beats_o       = BW'(min_w);
    end
`else
    // Without the page clamp the burst is limited by length only.
    always_comb begin
        rem_w     = CW'(remaining_i);
        max_w     = CW'(1) << AXI_LEN_W;
        min_len_w = (rem_w < max_w) ? rem_w : max_w;
        min_w     = min_len_w;
        beats_o   = BW'(min_w);
    end
`endif

endmodule

// File: rtl/iob_axi_burst_split.sv
// iob_axi_burst_split
// Splits one linear read transfer (start address + word count) into a
// sequence of AXI INCR bursts issued one at a time to the read engine.
// Burst errors are OR-ed into a sticky transfer status; they never abort.
// Optional macro: IOB_AXI_BURST_SPLIT_4K_EN (keeps bursts inside 4 KB pages).
module iob_axi_burst_split
    import iob_axi_burst_split_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int AXI_LEN_W = 8,
    parameter int LEN_W     = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [LEN_W-1:0]      len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    iob_axi_burst_split_if.master cmd
);
    localparam int                BYTES      = DATA_W / 8;
    localparam int                BYTE_SHIFT = $clog2(BYTES);
    localparam int                BW         = beats_width(LEN_W);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [BW-1:0]        rem_q, rem_d;
    logic [BW-1:0]        beats_q, beats_d;
    logic [BW-1:0]        calc_beats;
    logic [AXI_LEN_W-1:0] length_q, length_d;
    logic                 error_q, error_d;
    logic                 done_q, done_d;

    iob_axi_burst_len_calc #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .AXI_LEN_W(AXI_LEN_W),
        .LEN_W    (LEN_W)
    ) u_len_calc (
        .addr_i     (addr_q),
        .remaining_i(rem_q),
        .beats_o    (calc_beats)
    );

    // Next-state and datapath updates; every register holds unless its state acts on it.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        beats_d  = beats_q;
        length_d = length_q;
        error_d  = error_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        state_d = CALC;
                        addr_d  = addr_i & ALIGN_MASK;
                        rem_d   = BW'(len_i);
                        error_d = 1'b0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            CALC: begin
                beats_d  = calc_beats;
                length_d = AXI_LEN_W'(calc_beats - BW'(1));
                state_d  = ISSUE;
            end
            ISSUE: begin
                if (!cmd.ready) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (cmd.ready) begin
                    error_d = error_q | cmd.error;
                    addr_d  = addr_q + (ADDR_W'(beats_q) << BYTE_SHIFT);
                    rem_d   = rem_q - beats_q;
                    if (rem_d == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            beats_q  <= '0;
            length_q <= '0;
            error_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            beats_q  <= beats_d;
            length_q <= length_d;
            error_q  <= error_d;
            done_q   <= done_d;
        end
    end

    assign cmd.run    = (state_q == ISSUE);
    assign cmd.addr   = addr_q;
    assign cmd.length = length_q;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign error_o    = error_q;

endmodule

// File: tb/tb_iob_axi_burst_split.sv
// tb_iob_axi_burst_split
// Directed self-checking bench for iob_axi_burst_split. The bench acts as the
// read engine, driving ready/error by hand and checking every burst command.
// Expected burst lists follow IOB_AXI_BURST_SPLIT_4K_EN when it is defined.
module tb_iob_axi_burst_split;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int AXI_LEN_W = 8;
    localparam int LEN_W     = 16;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic [ADDR_W-1:0] addr_i;
    logic [LEN_W-1:0]  len_i;
    logic              busy_o;
    logic              done_o;
    logic              error_o;

    int checkCount = 0;
    int errorCount = 0;

    iob_axi_burst_split_if #(.ADDR_W(ADDR_W), .AXI_LEN_W(AXI_LEN_W)) cmd_if ();

    iob_axi_burst_split #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .AXI_LEN_W(AXI_LEN_W),
        .LEN_W    (LEN_W)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start_i(start_i),
        .addr_i (addr_i),
        .len_i  (len_i),
        .busy_o (busy_o),
        .done_o (done_o),
        .error_o(error_o),
        .cmd    (cmd_if.master)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    // Hard stop in case the bench itself gets stuck.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Pulse start and check the T+1 / T+2 response.
    task automatic applyStimulus(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
        @(negedge clk_i);
        start_i = 1'b1;
        addr_i  = a;
        len_i   = l;
        @(negedge clk_i);
        start_i = 1'b0;
        checkOutput("busy_t1", 32'(busy_o), 32'(l != 0));
        checkOutput("done_t1", 32'(done_o), 32'(l == 0));
        checkOutput("run_t1", 32'(cmd_if.run), 32'h0);
        if (l != 0) checkOutput("error_clr_t1", 32'(error_o), 32'h0);
        @(negedge clk_i);
        checkOutput("run_t2", 32'(cmd_if.run), 32'(l != 0));
        if (l == 0) begin
            checkOutput("done_t2", 32'(done_o), 32'h0);
            checkOutput("busy_t2", 32'(busy_o), 32'h0);
        end
    endtask

    // Act as the read engine for one burst and check the command and completion.
    task automatic serveBurst(input logic [ADDR_W-1:0] expAddr, input logic [AXI_LEN_W-1:0] expLen,
                              input int hold, input logic err, input logic last, input logic expErr);
        int waitCycles;
        waitCycles = 0;
        while (cmd_if.run !== 1'b1 && waitCycles < 50) begin
            @(negedge clk_i);
            waitCycles++;
        end
        checkOutput("run_seen", 32'(cmd_if.run), 32'h1);
        checkOutput("burst_addr", cmd_if.addr, expAddr);
        checkOutput("burst_length", 32'(cmd_if.length), 32'(expLen));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            checkOutput("hold_run", 32'(cmd_if.run), 32'h1);
            checkOutput("hold_addr", cmd_if.addr, expAddr);
            checkOutput("hold_length", 32'(cmd_if.length), 32'(expLen));
        end
        cmd_if.ready = 1'b0;
        @(negedge clk_i);
        checkOutput("run_drop", 32'(cmd_if.run), 32'h0);
        checkOutput("busy_mid", 32'(busy_o), 32'h1);
        @(negedge clk_i);
        @(negedge clk_i);
        cmd_if.ready = 1'b1;
        cmd_if.error = err;
        @(negedge clk_i);
        cmd_if.error = 1'b0;
        if (last) begin
            checkOutput("done_end", 32'(done_o), 32'h1);
            checkOutput("busy_end", 32'(busy_o), 32'h0);
            checkOutput("error_end", 32'(error_o), 32'(expErr));
            @(negedge clk_i);
            checkOutput("done_pulse", 32'(done_o), 32'h0);
        end else begin
            checkOutput("done_mid", 32'(done_o), 32'h0);
            checkOutput("gap_run0", 32'(cmd_if.run), 32'h0);
            @(negedge clk_i);
            checkOutput("gap_run1", 32'(cmd_if.run), 32'h1);
        end
    endtask

    // Directed test sequence.
    initial begin
        rst_i        = 1'b1;
        start_i      = 1'b0;
        addr_i       = '0;
        len_i        = '0;
        cmd_if.ready = 1'b1;
        cmd_if.error = 1'b0;
        repeat (2) @(negedge clk_i);
        checkOutput("rst_run", 32'(cmd_if.run), 32'h0);
        checkOutput("rst_busy", 32'(busy_o), 32'h0);
        checkOutput("rst_done", 32'(done_o), 32'h0);
        checkOutput("rst_error", 32'(error_o), 32'h0);
        checkOutput("rst_addr", cmd_if.addr, 32'h0);
        checkOutput("rst_length", 32'(cmd_if.length), 32'h0);
        rst_i = 1'b0;

        $display("[TB] two-burst transfer with 5-cycle ready hold");
        applyStimulus(32'h000, 16'd300);
        serveBurst(32'h000, 8'd255, 5, 1'b0, 1'b0, 1'b0);
        serveBurst(32'h400, 8'd43, 0, 1'b0, 1'b1, 1'b0);

        $display("[TB] transfer near a 4 KB page end");
        applyStimulus(32'hF00, 16'd100);
`ifdef IOB_AXI_BURST_SPLIT_4K_EN
        serveBurst(32'hF00, 8'd63, 0, 1'b0, 1'b0, 1'b0);
        serveBurst(32'h1000, 8'd35, 0, 1'b0, 1'b1, 1'b0);
`else
        serveBurst(32'hF00, 8'd99, 0, 1'b0, 1'b1, 1'b0);
`endif

        $display("[TB] empty transfer");
        applyStimulus(32'h123, 16'd0);
        repeat (3) begin
            @(negedge clk_i);
            checkOutput("empty_run", 32'(cmd_if.run), 32'h0);
            checkOutput("empty_busy", 32'(busy_o), 32'h0);
        end

        $display("[TB] error on first burst");
        applyStimulus(32'h2000, 16'd260);
        serveBurst(32'h2000, 8'd255, 1, 1'b1, 1'b0, 1'b0);
        serveBurst(32'h2400, 8'd3, 0, 1'b0, 1'b1, 1'b1);
        @(negedge clk_i);
        checkOutput("error_sticky", 32'(error_o), 32'h1);

        $display("[TB] reset while waiting for burst completion");
        applyStimulus(32'h100, 16'd10);
        cmd_if.ready = 1'b0;
        @(negedge clk_i);
        checkOutput("pre_rst_busy", 32'(busy_o), 32'h1);
        checkOutput("pre_rst_length", 32'(cmd_if.length), 32'h9);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i        = 1'b0;
        cmd_if.ready = 1'b1;
        checkOutput("mid_rst_run", 32'(cmd_if.run), 32'h0);
        checkOutput("mid_rst_busy", 32'(busy_o), 32'h0);
        checkOutput("mid_rst_done", 32'(done_o), 32'h0);
        checkOutput("mid_rst_error", 32'(error_o), 32'h0);
        checkOutput("mid_rst_addr", cmd_if.addr, 32'h0);
        checkOutput("mid_rst_length", 32'(cmd_if.length), 32'h0);

        $display("[TB] unaligned single-word transfer after reset");
        applyStimulus(32'h47, 16'd1);
        serveBurst(32'h44, 8'd0, 0, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
